// File: rtl/cw310_crypt_ctrl_if.sv
// Register bus between the USB front-end and the crypto controller.
// The host side (master) drives address/data/strobes; the block (slave)
// returns the registered read byte.
interface cw310_crypt_ctrl_if #(
  parameter int pADDR_WIDTH   = 8,
  parameter int pBYTECNT_SIZE = 7
);
  logic [pADDR_WIDTH-1:0]   reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic                     reg_addrvalid;
  logic [7:0]               reg_datai;
  logic                     reg_write;
  logic                     reg_read;
  logic [7:0]               reg_datao;

  modport master (
    output reg_address, reg_bytecnt, reg_addrvalid, reg_datai, reg_write, reg_read,
    input  reg_datao
  );

  modport slave (
    input  reg_address, reg_bytecnt, reg_addrvalid, reg_datai, reg_write, reg_read,
    output reg_datao
  );
endinterface

// File: rtl/cw310_crypt_ctrl.sv
// CW310 crypto controller: plaintext/key register bank, start sequencing
// (register GO or synchronized usb_trigger edge), ciphertext capture,
// busy status and scope trigger generation.
module cw310_crypt_ctrl #(
  parameter int pADDR_WIDTH   = 8,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pPT_WIDTH     = 128,
  parameter int pKEY_WIDTH    = 128,
  parameter logic [pADDR_WIDTH-1:0] pREG_CRYPT_GO        = pADDR_WIDTH'(8'h05),
  parameter logic [pADDR_WIDTH-1:0] pREG_CRYPT_TEXTIN    = pADDR_WIDTH'(8'h06),
  parameter logic [pADDR_WIDTH-1:0] pREG_CRYPT_CIPHEROUT = pADDR_WIDTH'(8'h07),
  parameter logic [pADDR_WIDTH-1:0] pREG_CRYPT_KEY       = pADDR_WIDTH'(8'h0a)
) (
  input  logic                  usb_clk,
  input  logic                  reset_n,
  cw310_crypt_ctrl_if.slave     reg_bus,
  input  logic                  exttrigger_in,
  output logic [pPT_WIDTH-1:0]  crypt_textout,
  output logic [pKEY_WIDTH-1:0] crypt_keyout,
  output logic                  crypt_init,
  output logic                  crypt_start,
  input  logic                  crypt_ready,
  input  logic                  crypt_done,
  input  logic [pPT_WIDTH-1:0]  crypt_cipherin,
  output logic                  crypt_busy,
  output logic                  trigger_out
);

  localparam int PT_BYTES  = pPT_WIDTH / 8;
  localparam int KEY_BYTES = pKEY_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_WAIT_KEY  = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  state_t                  state_q;
  logic [pPT_WIDTH-1:0]    text_q;
  logic [pKEY_WIDTH-1:0]   key_q;
  logic [pPT_WIDTH-1:0]    cipher_q;
  logic                    key_dirty_q;
  logic                    init_q;
  logic                    start_q;
  logic                    busy_q;
  logic                    trig_q;
  logic [1:0]              sync_q;
  logic                    trig_prev_q;
  logic [7:0]              datao_q;

  logic                    wr_s;
  logic                    wr_text_s;
  logic                    wr_key_s;
  logic                    go_req_s;
  logic                    trig_start_s;
  logic                    start_req_s;
  logic [7:0]              rd_byte_s;

  // Byte n of a plaintext-wide register; out-of-range index reads as zero.
  function automatic logic [7:0] pt_byte(input logic [pPT_WIDTH-1:0] v,
                                         input logic [pBYTECNT_SIZE-1:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < PT_BYTES; i++) begin
      if (32'(idx) == i) r = v[i*8 +: 8];
    end
    return r;
  endfunction

  // Byte n of a key-wide register; out-of-range index reads as zero.
  function automatic logic [7:0] key_byte(input logic [pKEY_WIDTH-1:0] v,
                                          input logic [pBYTECNT_SIZE-1:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < KEY_BYTES; i++) begin
      if (32'(idx) == i) r = v[i*8 +: 8];
    end
    return r;
  endfunction

  assign wr_s         = reg_bus.reg_write & reg_bus.reg_addrvalid;
  assign wr_text_s    = wr_s && (reg_bus.reg_address == pREG_CRYPT_TEXTIN);
  assign wr_key_s     = wr_s && (reg_bus.reg_address == pREG_CRYPT_KEY);
  assign go_req_s     = wr_s && (reg_bus.reg_address == pREG_CRYPT_GO) && reg_bus.reg_datai[0];
  // Rising edge of the synchronized trigger; compared against the
  // previous synchronized sample so a held-high level starts only once.
  assign trig_start_s = sync_q[1] & ~trig_prev_q;
  assign start_req_s  = go_req_s | trig_start_s;

  assign crypt_textout     = text_q;
  assign crypt_keyout      = key_q;
  assign crypt_init        = init_q;
  assign crypt_start       = start_q;
  assign crypt_busy        = busy_q;
  assign trigger_out       = trig_q;
  assign reg_bus.reg_datao = datao_q;

  // Byte-addressed writes into the plaintext and key registers.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      text_q <= '0;
      key_q  <= '0;
    end else begin
      for (int i = 0; i < PT_BYTES; i++) begin
        if (wr_text_s && (32'(reg_bus.reg_bytecnt) == i)) text_q[i*8 +: 8] <= reg_bus.reg_datai;
      end
      for (int i = 0; i < KEY_BYTES; i++) begin
        if (wr_key_s && (32'(reg_bus.reg_bytecnt) == i)) key_q[i*8 +: 8] <= reg_bus.reg_datai;
      end
    end
  end

  // Two-flop synchronizer for usb_trigger plus the edge-detect history flop.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 2'b00;
      trig_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], exttrigger_in};
      trig_prev_q <= sync_q[1];
    end
  end

  // Key must be re-expanded after any key write; cleared as crypt_init issues.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      key_dirty_q <= 1'b1;
    end else if (wr_key_s) begin
      key_dirty_q <= 1'b1;
    end else if ((state_q == ST_IDLE) && start_req_s && key_dirty_q) begin
      key_dirty_q <= 1'b0;
    end else begin
      key_dirty_q <= key_dirty_q;
    end
  end

  // Sequencing FSM with registered core strobes, busy flag and scope trigger.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      init_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      trig_q   <= 1'b0;
      cipher_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req_s) begin
            busy_q <= 1'b1;
            if (key_dirty_q) begin
              state_q <= ST_INIT;
              init_q  <= 1'b1;
            end else begin
              state_q <= ST_START;
              start_q <= 1'b1;
              trig_q  <= 1'b1;
            end
          end
        end
        ST_INIT: begin
          init_q  <= 1'b0;
          state_q <= ST_WAIT_KEY;
        end
        ST_WAIT_KEY: begin
          if (crypt_ready) begin
            state_q <= ST_START;
            start_q <= 1'b1;
            trig_q  <= 1'b1;
          end
        end
        ST_START: begin
          start_q <= 1'b0;
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (crypt_done) begin
            cipher_q <= crypt_cipherin;
            busy_q   <= 1'b0;
            trig_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          init_q  <= 1'b0;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
          trig_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read-data mux for the addressed register byte.
  always_comb begin
    rd_byte_s = 8'h00;
    case (reg_bus.reg_address)
      pREG_CRYPT_TEXTIN:    rd_byte_s = pt_byte(text_q, reg_bus.reg_bytecnt);
      pREG_CRYPT_KEY:       rd_byte_s = key_byte(key_q, reg_bus.reg_bytecnt);
      pREG_CRYPT_CIPHEROUT: rd_byte_s = pt_byte(cipher_q, reg_bus.reg_bytecnt);
      pREG_CRYPT_GO:        rd_byte_s = {7'b0000000, busy_q};
      default:              rd_byte_s = 8'h00;
    endcase
  end

  // Registered read data; zero whenever no read is in progress.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      datao_q <= 8'h00;
    end else if (reg_bus.reg_read) begin
      datao_q <= rd_byte_s;
    end else begin
      datao_q <= 8'h00;
    end
  end

endmodule

// File: tb/tb_cw310_crypt_ctrl.sv
// Directed bench for cw310_crypt_ctrl: a register-access vector table plus
// hand-written sequences, against a small behavioural AES-core stand-in
// whose "ciphertext" is plaintext XOR the key latched at the last init.
module tb_cw310_crypt_ctrl;

  localparam logic [7:0] A_GO   = 8'h05;
  localparam logic [7:0] A_TEXT = 8'h06;
  localparam logic [7:0] A_CIPH = 8'h07;
  localparam logic [7:0] A_KEY  = 8'h0a;
  localparam logic [7:0] A_NONE = 8'h20;

  localparam logic [127:0] TEXT1 = 128'h12345678abcdef0187654321deadbeef;
  localparam logic [127:0] KEY1  = 128'habcdef0112345678deadbeef87654321;

  logic         usb_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         exttrigger_in = 1'b0;
  logic [127:0] crypt_textout, crypt_keyout;
  logic         crypt_init, crypt_start, crypt_busy, trigger_out;
  logic         crypt_ready = 1'b1;
  logic         crypt_done = 1'b0;
  logic [127:0] crypt_cipherin = '0;

  cw310_crypt_ctrl_if #(.pADDR_WIDTH(8), .pBYTECNT_SIZE(7)) bus ();

  cw310_crypt_ctrl dut (
    .usb_clk        (usb_clk),
    .reset_n        (reset_n),
    .reg_bus        (bus),
    .exttrigger_in  (exttrigger_in),
    .crypt_textout  (crypt_textout),
    .crypt_keyout   (crypt_keyout),
    .crypt_init     (crypt_init),
    .crypt_start    (crypt_start),
    .crypt_ready    (crypt_ready),
    .crypt_done     (crypt_done),
    .crypt_cipherin (crypt_cipherin),
    .crypt_busy     (crypt_busy),
    .trigger_out    (trigger_out)
  );

  always #5 usb_clk = ~usb_clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Core stand-in state
  int           rdy_cnt = 0;
  int           done_cnt = 0;
  int           init_cnt = 0;
  int           start_cnt = 0;
  logic [127:0] key_lat = '0;
  logic [127:0] txt_lat = '0;
  logic         trig_at_start = 1'b0;
  logic         trig_at_done = 1'b0;
  logic         busy_at_done = 1'b0;

  // Core stand-in: reacts to init/start at the falling edge.
  always @(negedge usb_clk) begin
    crypt_done = 1'b0;
    if (crypt_init) begin
      key_lat     = crypt_keyout;
      crypt_ready = 1'b0;
      rdy_cnt     = 4;
      init_cnt++;
    end else if (rdy_cnt > 0) begin
      rdy_cnt--;
      if (rdy_cnt == 0) crypt_ready = 1'b1;
    end
    if (crypt_start) begin
      txt_lat       = crypt_textout;
      done_cnt      = 16;
      trig_at_start = trigger_out;
      start_cnt++;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        crypt_done     = 1'b1;
        crypt_cipherin = txt_lat ^ key_lat;
        busy_at_done   = crypt_busy;
        trig_at_done   = trigger_out;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge usb_clk);
    #1;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [6:0] bc, input logic [7:0] d);
    @(negedge usb_clk);
    bus.reg_address   = a;
    bus.reg_bytecnt   = bc;
    bus.reg_datai     = d;
    bus.reg_addrvalid = 1'b1;
    bus.reg_write     = 1'b1;
    @(negedge usb_clk);
    bus.reg_write     = 1'b0;
    bus.reg_addrvalid = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, input logic [6:0] bc, output logic [7:0] d);
    @(negedge usb_clk);
    bus.reg_address   = a;
    bus.reg_bytecnt   = bc;
    bus.reg_addrvalid = 1'b1;
    bus.reg_read      = 1'b1;
    tick();
    d = bus.reg_datao;
    bus.reg_read      = 1'b0;
    bus.reg_addrvalid = 1'b0;
  endtask

  task automatic wr128(input logic [7:0] a, input logic [127:0] v);
    for (int i = 15; i >= 0; i--) reg_wr(a, 7'(i), v[i*8 +: 8]);
  endtask

  task automatic rd128(input logic [7:0] a, output logic [127:0] v);
    logic [7:0] b;
    for (int i = 15; i >= 0; i--) begin
      reg_rd(a, 7'(i), b);
      v[i*8 +: 8] = b;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (crypt_busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_within_bound", {127'd0, crypt_busy}, 128'd0);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [6:0] bc;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [7:0]   b;
    logic [127:0] v, text2, text3, key4, c_prev;
    int           s0, i0;

    tbl[0]  = '{1'b0, A_TEXT, 7'd0,  8'h00, 8'h00};
    tbl[1]  = '{1'b0, A_TEXT, 7'd15, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, A_KEY,  7'd0,  8'h00, 8'h00};
    tbl[3]  = '{1'b0, A_KEY,  7'd15, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, A_CIPH, 7'd0,  8'h00, 8'h00};
    tbl[5]  = '{1'b0, A_CIPH, 7'd15, 8'h00, 8'h00};
    tbl[6]  = '{1'b0, A_GO,   7'd0,  8'h00, 8'h00};
    tbl[7]  = '{1'b0, A_NONE, 7'd0,  8'h00, 8'h00};
    tbl[8]  = '{1'b1, A_TEXT, 7'd0,  8'ha5, 8'h00};
    tbl[9]  = '{1'b0, A_TEXT, 7'd0,  8'h00, 8'ha5};
    tbl[10] = '{1'b0, A_TEXT, 7'd1,  8'h00, 8'h00};
    tbl[11] = '{1'b1, A_TEXT, 7'd16, 8'hff, 8'h00};
    tbl[12] = '{1'b0, A_TEXT, 7'd16, 8'h00, 8'h00};
    tbl[13] = '{1'b1, A_CIPH, 7'd0,  8'h77, 8'h00};
    tbl[14] = '{1'b0, A_CIPH, 7'd0,  8'h00, 8'h00};
    tbl[15] = '{1'b1, A_KEY,  7'd15, 8'h3c, 8'h00};
    tbl[16] = '{1'b0, A_KEY,  7'd15, 8'h00, 8'h3c};

    bus.reg_address = 8'h00; bus.reg_bytecnt = 7'd0; bus.reg_addrvalid = 1'b0;
    bus.reg_datai = 8'h00; bus.reg_write = 1'b0; bus.reg_read = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", {127'd0, crypt_busy}, 128'd0);
    chk("rst_trig", {127'd0, trigger_out}, 128'd0);
    chk("rst_init_start", {126'd0, crypt_init, crypt_start}, 128'd0);
    chk("rst_text_key", crypt_textout | crypt_keyout, 128'd0);
    @(negedge usb_clk);
    reset_n = 1'b1;

    // Register access table
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].wr) begin
        reg_wr(tbl[i].addr, tbl[i].bc, tbl[i].data);
      end else begin
        reg_rd(tbl[i].addr, tbl[i].bc, b);
        chk($sformatf("tbl_rd_%0d", i), {120'd0, b}, {120'd0, tbl[i].exp});
      end
    end
    tick();
    chk("datao_idle_zero", {120'd0, bus.reg_datao}, 128'd0);
    chk("text_partial", crypt_textout, 128'h000000000000000000000000000000a5);
    chk("key_partial", crypt_keyout, {8'h3c, 120'd0});

    // GO with dirty key: init then start
    wr128(A_TEXT, TEXT1);
    wr128(A_KEY, KEY1);
    chk("textout", crypt_textout, TEXT1);
    chk("keyout", crypt_keyout, KEY1);
    reg_wr(A_GO, 7'd0, 8'h01);
    chk("go_busy_init", {126'd0, crypt_busy, crypt_init}, 128'd3);
    chk("go_no_start_yet", {127'd0, crypt_start}, 128'd0);
    wait_idle();
    chk("go_init_cnt", 128'(init_cnt), 128'd1);
    chk("go_start_cnt", 128'(start_cnt), 128'd1);
    chk("trig_at_start", {127'd0, trig_at_start}, 128'd1);
    chk("trig_busy_at_done", {126'd0, trig_at_done, busy_at_done}, 128'd3);
    chk("trig_low_after", {127'd0, trigger_out}, 128'd0);
    rd128(A_CIPH, v);
    chk("cipher_go", v, TEXT1 ^ KEY1);

    // Trigger start with clean key, held high 10 cycles
    reg_wr(A_TEXT, 7'd0, 8'h01);
    text2 = {TEXT1[127:8], 8'h01};
    s0 = start_cnt; i0 = init_cnt;
    @(negedge usb_clk);
    exttrigger_in = 1'b1;
    tick(); tick();
    chk("trig_lat_not_yet", {127'd0, crypt_busy}, 128'd0);
    tick();
    chk("trig_lat_busy", {127'd0, crypt_busy}, 128'd1);
    repeat (7) tick();
    exttrigger_in = 1'b0;
    wait_idle();
    chk("trig_start_cnt", 128'(start_cnt - s0), 128'd1);
    chk("trig_init_cnt", 128'(init_cnt - i0), 128'd0);
    rd128(A_CIPH, v);
    chk("cipher_trig", v, text2 ^ KEY1);
    c_prev = text2 ^ KEY1;

    // Overlap: GO, trigger, key write while busy
    reg_wr(A_TEXT, 7'd1, 8'h55);
    text3 = {text2[127:16], 8'h55, text2[7:0]};
    key4  = {KEY1[127:8], 8'h99};
    s0 = start_cnt; i0 = init_cnt;
    reg_wr(A_GO, 7'd0, 8'h01);
    chk("clean_go_start", {125'd0, crypt_init, crypt_start, trigger_out}, 128'd3);
    repeat (2) tick();
    reg_wr(A_GO, 7'd0, 8'h01);
    @(negedge usb_clk);
    exttrigger_in = 1'b1;
    tick(); tick();
    exttrigger_in = 1'b0;
    repeat (3) tick();
    reg_rd(A_CIPH, 7'd1, b);
    chk("cipher_old_while_busy", {120'd0, b}, {120'd0, c_prev[15:8]});
    reg_wr(A_KEY, 7'd0, 8'h99);
    chk("still_busy", {127'd0, crypt_busy}, 128'd1);
    wait_idle();
    repeat (6) tick();
    chk("overlap_start_cnt", 128'(start_cnt - s0), 128'd1);
    chk("overlap_no_init", 128'(init_cnt - i0), 128'd0);
    rd128(A_CIPH, v);
    chk("cipher_overlap", v, text3 ^ KEY1);

    // Next op after key change must re-init
    reg_wr(A_GO, 7'd0, 8'h01);
    chk("rekey_init", {126'd0, crypt_init, crypt_start}, 128'd2);
    wait_idle();
    chk("rekey_init_cnt", 128'(init_cnt - i0), 128'd1);
    rd128(A_CIPH, v);
    chk("cipher_rekey", v, text3 ^ key4);

    // Reset mid-operation, later crypt_done ignored
    reg_wr(A_GO, 7'd0, 8'h01);
    repeat (4) tick();
    chk("pre_reset_busy", {127'd0, crypt_busy}, 128'd1);
    reset_n = 1'b0;
    #1;
    chk("in_reset_busy_trig", {126'd0, crypt_busy, trigger_out}, 128'd0);
    tick();
    @(negedge usb_clk);
    reset_n = 1'b1;
    repeat (20) tick();
    chk("post_reset_busy_trig", {126'd0, crypt_busy, trigger_out}, 128'd0);
    rd128(A_CIPH, v);
    chk("post_reset_cipher", v, 128'd0);
    chk("post_reset_text", crypt_textout, 128'd0);
    reg_wr(A_GO, 7'd0, 8'h01);
    chk("post_reset_dirty", {126'd0, crypt_init, crypt_start}, 128'd2);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
